adder_input_sequencer: RTL and testbench
========================================

# adder_input_sequencer

Upstream feeder for the 16-bit feedback accumulator. Buffers incoming samples in a small FIFO and presents them to the accumulator input one word per cycle. It drives zero whenever no sample is issued, so the running sum holds. It groups samples into frames of FRAME_LEN words: at each frame end it flags the completed sum and pulses a clear toward the accumulator, which starts the next frame from zero.

## Interface
- WIDTH, 16, sample and accumulator data width.
- DEPTH, 4, FIFO depth; power of two, ≥2.
- FRAME_LEN, 8, samples per frame; ≥2.
- LW, $clog2(DEPTH)+1, level counter width (derived).

Ports:
- clk  in  1  single clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
- s_data  in  WIDTH  incoming sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept a word; equals (level != DEPTH).
- acc_in  out  WIDTH  word to the accumulator input; registered.
- acc_clr  out  1  one-cycle clear request to the accumulator; registered. Top level ORs it with system reset into the accumulator's reset.
- frame_done  out  1  accumulator output holds the complete frame sum this cycle; registered.
- level  out  LW  current FIFO occupancy.

## Operation
- Push: a word is written at an edge with s_valid && s_ready. When full, s_ready is low even if a pop occurs in the same cycle, so there is no full-bypass.
- Pop eligibility: level != 0 and state is RUN or DONE.
- Each edge: acc_in <= pop ? FIFO head : 0. A non-popped cycle presents 0, so the accumulator holds its value.
- Simultaneous push and pop when not full: level is unchanged and ordering is preserved. Pointers wrap modulo DEPTH.
- FSM (state, count in 0..FRAME_LEN-1):
  - RUN: a pop increments count. A pop with count == FRAME_LEN-1 goes to SETTLE with count <= 0.
  - SETTLE: no pop. acc_in still holds the last word, which the accumulator adds at this state's exit edge. Next state is DONE.
  - DONE: frame_done = 1 and acc_clr = 1 for exactly this cycle; the accumulator output equals the frame sum. Next state is RUN. A pop here is allowed: its word is presented after the clearing edge and summed into zero, with count <= 1.
- A stall (empty FIFO) in RUN keeps state and count. Frames span arbitrary gaps.
- Arithmetic: data is passed unmodified. The frame sum is modulo 2^WIDTH; wrap is the accumulator's concern and is not flagged.
- Reset (asserted at any time, including mid-frame): FIFO empty, level 0, state RUN, count 0, acc_in 0, acc_clr 0, frame_done 0, s_ready 1. A partial frame is discarded. The accumulator is cleared by the same system reset.

## Timing
- Minimum latency is 1 cycle: a word accepted at edge e0 appears on acc_in after edge e1 and is in the accumulator sum after e2.
- Last pop of a frame at edge eN gives SETTLE after eN, then DONE after eN+1 (frame_done/acc_clr high), then the accumulator clears at eN+2.
- Throughput with continuous input is FRAME_LEN samples per FRAME_LEN+1 cycles. The SETTLE cycle is the only forced bubble.
- s_ready, level and frame_done change only on clock edges; there is no combinational path from s_valid to s_ready.

## Test plan
- Reset mid-frame: push 5,6, pop them, assert reset. Outputs go to their reset values asynchronously. The next frame sum counts only post-reset data, with no 5/6 contribution.
- Back-to-back frame (FRAME_LEN=4): push 1,2,3,4 at e0..e3. acc_in = 1,2,3,4 after e1..e4 and 0 after e5. frame_done/acc_clr high only between e5 and e6, with accumulator out = 10. Out = 0 after e6.
- Stalled input: push 7, three idle cycles, push 1,1,1. acc_in = 0 during the gap, frame completes with sum 10, and count does not advance while empty.
- Full FIFO (DEPTH=4): hold s_valid with the downstream path stalled in SETTLE/DONE. level reaches 4 and s_ready drops. No word is lost or duplicated: the pushed sequence 1..12 gives frames summing 10, 26 and 42.
- Continuous stream of 8 samples of 0xFFFF: first frame sum 0xFFFC (modulo). The second frame's first pop in DONE yields a second sum equal to 0xFFFC, with no carry from frame 1.
- Simultaneous push and pop at level 2: level stays 2 and FIFO order is preserved across pointer wrap after 6+ words.

Source files
------------

// File: rtl/adder_input_sequencer.sv
// adder_input_sequencer: FIFO-buffered feeder that presents one sample per
// cycle to a 16-bit feedback accumulator and frames the sums.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   s_data     incoming sample
//   s_valid    s_data valid
//   s_ready    FIFO not full (level != DEPTH)
//   acc_in     registered word to the accumulator, zero when idle
//   acc_clr    registered one-cycle clear toward the accumulator
//   frame_done registered: accumulator holds the complete frame sum
//   level      FIFO occupancy
module adder_input_sequencer #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 8,
  parameter int LW        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] acc_in,
  output logic             acc_clr,
  output logic             frame_done,
  output logic [LW-1:0]    level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [WIDTH-1:0] acc_in_q, acc_in_d;
  logic             done_q, done_d;
  logic             push, pop;

  // Full blocks pushes even if a pop happens the same cycle (no bypass).
  assign s_ready = (lvl_q != LW'(DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = (lvl_q != '0) &&
                   ((state_q == RUN) || (state_q == DONE));

  always_comb begin
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    lvl_d    = lvl_q;
    acc_in_d = '0;
    if (push) begin
      mem_d[wr_q] = s_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      acc_in_d = mem_q[rd_q];
      rd_d     = rd_q + 1'b1;
    end
    if (push && !pop) begin
      lvl_d = lvl_q + 1'b1;
    end else if (!push && pop) begin
      lvl_d = lvl_q - 1'b1;
    end
  end

  // SETTLE lets the accumulator absorb the last word; DONE then exposes
  // the sum while the clear is requested. A DONE pop starts the new frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (pop) begin
          if (cnt_q == CW'(FRAME_LEN - 1)) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SETTLE: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = RUN;
        cnt_d   = pop ? CW'(1) : '0;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
      wr_q     <= '0;
      rd_q     <= '0;
      lvl_q    <= '0;
      acc_in_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      lvl_q    <= lvl_d;
      acc_in_q <= acc_in_d;
      done_q   <= done_d;
    end
  end

  assign acc_in     = acc_in_q;
  assign acc_clr    = done_q;
  assign frame_done = done_q;
  assign level      = lvl_q;

endmodule

// File: tb/tb_adder_input_sequencer.sv
// tb_adder_input_sequencer: vector table plus scoreboard bench with a
// behavioural accumulator, run with DEPTH=4 and FRAME_LEN=4.
module tb_adder_input_sequencer;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int FL = 4;
  localparam int LW = 3;

  logic          clk;
  logic          reset;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  acc_in;
  logic          acc_clr;
  logic          frame_done;
  logic [LW-1:0] level;

  adder_input_sequencer #(
    .WIDTH(W), .DEPTH(D), .FRAME_LEN(FL)
  ) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .acc_in(acc_in),
    .acc_clr(acc_clr), .frame_done(frame_done),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream accumulator: clear request acts at the next edge.
  logic [W-1:0] acc_sum;
  always @(posedge clk or negedge reset) begin
    if (!reset)       acc_sum <= '0;
    else if (acc_clr) acc_sum <= '0;
    else              acc_sum <= acc_sum + acc_in;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  logic [W-1:0] data_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] tb_sum;
  int           tb_cnt;
  int           max_lvl;
  logic         saw_nr;

  always @(negedge clk) begin
    if (reset) begin
      if (acc_in != '0) begin
        if (data_q.size() == 0) check("acc_in_unexpected", acc_in, 0);
        else check("acc_in_order", acc_in, data_q.pop_front());
      end
      if (frame_done || acc_clr) begin
        check("clr_eq_done", acc_clr, frame_done);
        if (exp_q.size() == 0) check("frame_unexpected", frame_done, 0);
        else check("frame_sum", acc_sum, exp_q.pop_front());
      end
    end
  end

  task automatic record(input logic [W-1:0] d);
    data_q.push_back(d);
    tb_sum = tb_sum + d;
    tb_cnt++;
    if (tb_cnt == FL) begin
      exp_q.push_back(tb_sum);
      tb_sum = '0;
      tb_cnt = 0;
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive(input logic v, input logic [W-1:0] d,
                       output logic acc);
    logic rdy;
    s_valid = v;
    s_data  = d;
    rdy     = s_ready;
    if (!rdy) saw_nr = 1'b1;
    @(posedge clk);
    acc = v && rdy;
    if (acc) record(d);
    #1;
    if (int'(level) > max_lvl) max_lvl = int'(level);
  endtask

  task automatic push_word(input logic [W-1:0] d);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      drive(1'b1, d, acc);
      tries++;
    end
    if (!acc) check("push_timeout", acc, 1);
  endtask

  task automatic flush();
    int k;
    k = 0;
    s_valid = 1'b0;
    while ((exp_q.size() != 0 || data_q.size() != 0) && k < 80) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("flush_empty", exp_q.size() + data_q.size(), 0);
    check("acc_cleared", acc_sum, 0);
  endtask

  typedef struct {
    logic          v;
    logic [W-1:0]  d;
    logic [W-1:0]  acc;
    logic          fd;
    logic [LW-1:0] lvl;
    logic [W-1:0]  sum;
  } vec_t;

  vec_t tbl[12];
  logic acc_ok;

  initial begin
    // Eight back-to-back words: two frames, pointer wrap, DONE pop.
    tbl[0]  = '{1'b1, 16'd1, 16'd0, 1'b0, 3'd1, 16'd0};
    tbl[1]  = '{1'b1, 16'd2, 16'd1, 1'b0, 3'd1, 16'd0};
    tbl[2]  = '{1'b1, 16'd3, 16'd2, 1'b0, 3'd1, 16'd1};
    tbl[3]  = '{1'b1, 16'd4, 16'd3, 1'b0, 3'd1, 16'd3};
    tbl[4]  = '{1'b1, 16'd5, 16'd4, 1'b0, 3'd1, 16'd6};
    tbl[5]  = '{1'b1, 16'd6, 16'd0, 1'b1, 3'd2, 16'd10};
    tbl[6]  = '{1'b1, 16'd7, 16'd5, 1'b0, 3'd2, 16'd0};
    tbl[7]  = '{1'b1, 16'd8, 16'd6, 1'b0, 3'd2, 16'd5};
    tbl[8]  = '{1'b0, 16'd0, 16'd7, 1'b0, 3'd1, 16'd11};
    tbl[9]  = '{1'b0, 16'd0, 16'd8, 1'b0, 3'd0, 16'd18};
    tbl[10] = '{1'b0, 16'd0, 16'd0, 1'b1, 3'd0, 16'd26};
    tbl[11] = '{1'b0, 16'd0, 16'd0, 1'b0, 3'd0, 16'd0};

    tb_sum  = '0;
    tb_cnt  = 0;
    max_lvl = 0;
    saw_nr  = 1'b0;
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #12;
    check("rst_level", level, 0);
    check("rst_ready", s_ready, 1);
    check("rst_acc_in", acc_in, 0);
    check("rst_done", frame_done, 0);
    check("rst_clr", acc_clr, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].d, acc_ok);
      check($sformatf("tbl%0d_acc_in", i), acc_in, tbl[i].acc);
      check($sformatf("tbl%0d_done", i), frame_done, tbl[i].fd);
      check($sformatf("tbl%0d_clr", i), acc_clr, tbl[i].fd);
      check($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      check($sformatf("tbl%0d_sum", i), acc_sum, tbl[i].sum);
    end
    flush();

    // Reset mid-frame: 5 and 6 must not reach the next frame sum.
    drive(1'b1, 16'd5, acc_ok);
    drive(1'b1, 16'd6, acc_ok);
    drive(1'b0, 16'd0, acc_ok);
    check("pre_reset_acc_in", acc_in, 6);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_acc_in", acc_in, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_ready", s_ready, 1);
    check("mid_rst_done", frame_done, 0);
    data_q.delete();
    exp_q.delete();
    tb_sum = '0;
    tb_cnt = 0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    flush();

    // Stalled input: count holds while the FIFO is empty.
    push_word(16'd7);
    drive(1'b0, 16'd0, acc_ok);
    check("stall_acc_7", acc_in, 7);
    drive(1'b0, 16'd0, acc_ok);
    check("stall_gap0", acc_in, 0);
    drive(1'b0, 16'd0, acc_ok);
    check("stall_gap1", acc_in, 0);
    for (int i = 0; i < 3; i++) push_word(16'd1);
    flush();

    // Continuous stream fills the FIFO through the SETTLE bubbles.
    max_lvl = 0;
    saw_nr  = 1'b0;
    for (int w = 1; w <= 20; w++) push_word(16'(w));
    flush();
    check("full_level_max", max_lvl, 4);
    check("full_ready_drop", saw_nr, 1);

    // Modulo wrap with no carry between frames.
    for (int i = 0; i < 8; i++) push_word(16'hFFFF);
    flush();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
